// File: rtl/alert_ctrl.sv
// Alert countdown sequencer: debounced start/stop key, 1 Hz strobe, IDLE/RUN/PAUSE/ALARM
// control of the minute/second counter, and a timed blinking alarm.
`timescale 1ns/1ps
module alert_ctrl #(
  parameter int TICK_CYC    = 50_000_000,
  parameter int DB_CYC      = 1_000_000,
  parameter int BLINK_CYC   = 12_500_000,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic [1:0] KEY,
  input  logic       cnt_zero,
  input  logic       preset_zero,
  output logic       cnt_load,
  output logic       cnt_dec,
  output logic       run,
  output logic       alarm,
  output logic [1:0] st
);

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int DW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int SW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYC - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic            rst_n;
  logic            key_s1, key_s2, db_level, db_prev;
  logic [DW-1:0]   db_cnt;
  logic            press;
  logic [TW-1:0]   presc;
  logic            tick;
  logic [BW-1:0]   blink;
  logic [SW-1:0]   sec;
  logic            load_d;
  logic            zero_seen;

  assign rst_n = KEY[0];

  // Debounced level follows the synced key only after DB_CYC consecutive differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      db_level <= 1'b1;
      db_prev  <= 1'b1;
      db_cnt   <= '0;
    end else begin
      key_s1  <= KEY[1];
      key_s2  <= key_s1;
      db_prev <= db_level;
      if (key_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        db_level <= key_s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press     = db_prev & ~db_level;
  assign tick      = (presc == TICK_LAST);
  assign zero_seen = cnt_zero & ~load_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      load_d <= 1'b0;
    end else begin
      state  <= state_nx;
      load_d <= cnt_load;
    end
  end

  // cnt_load/cnt_dec are single-cycle command strobes with no backpressure: the
  // datapath acts on them in the cycle they are high.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (press && !preset_zero) begin
          cnt_load = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (zero_seen)  state_nx = ALARM;
        else if (press) state_nx = PAUSE;
        else if (tick)  cnt_dec  = 1'b1;
      end
      PAUSE: begin
        if (press) state_nx = RUN;
      end
      ALARM: begin
        if (press || (tick && sec == SEC_LAST)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Prescaler restarts on a fresh start and on alarm entry; it holds across pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if ((state == IDLE && state_nx == RUN) ||
                 (state != ALARM && state_nx == ALARM) || state_nx == IDLE) begin
      presc <= '0;
    end else if ((state == RUN && state_nx == RUN) ||
                 (state == ALARM && state_nx == ALARM)) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
      blink <= '0;
      sec   <= '0;
    end else if (state != ALARM && state_nx == ALARM) begin
      alarm <= 1'b1;
      blink <= '0;
      sec   <= '0;
    end else if (state == ALARM && state_nx == ALARM) begin
      if (blink == BLINK_LAST) begin
        blink <= '0;
        alarm <= ~alarm;
      end else begin
        blink <= blink + 1'b1;
      end
      if (tick) sec <= sec + 1'b1;
    end else begin
      alarm <= 1'b0;
      blink <= '0;
      sec   <= '0;
    end
  end

  assign run = (state == RUN);
  assign st  = state;

endmodule

// File: tb/tb_alert_ctrl.sv
// Bench for alert_ctrl: directed vector table, hand-written timing sequences and a
// randomized run checked every cycle against a behavioural model of the controller.
`timescale 1ns/1ps
module tb_alert_ctrl;

  localparam int TICK  = 10;
  localparam int DB    = 4;
  localparam int BLINK = 5;
  localparam int AT    = 3;
  localparam int W     = 16;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic       cnt_zero, preset_zero;
  logic       cnt_load, cnt_dec, run, alarm;
  logic [1:0] st;

  alert_ctrl #(
    .TICK_CYC(TICK), .DB_CYC(DB), .BLINK_CYC(BLINK), .ALARM_TICKS(AT)
  ) dut (
    .clk(clk), .KEY(key), .cnt_zero(cnt_zero), .preset_zero(preset_zero),
    .cnt_load(cnt_load), .cnt_dec(cnt_dec), .run(run), .alarm(alarm), .st(st)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic drv_key1 = 1'b1, drv_rst = 1'b0, drv_cz = 1'b0, drv_pz = 1'b0;
  bit   dp_auto = 1'b0;
  int   dp_preset = 0, dp_cnt = 0;

  logic       o_load, o_dec, o_run, o_alarm;
  logic [1:0] o_st;
  int         load_steps[$];
  int         dec_steps[$];
  logic [W-1:0] exp_q[$];

  // behavioural model state
  int  m_mode, m_streak, m_phase, m_age;
  bit  m_lvl, m_press_next, m_mask;
  bit  m_sync[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc_n, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_streak = 0; m_phase = 0; m_age = 0;
    m_lvl = 1'b1; m_press_next = 1'b0; m_mask = 1'b0;
    m_sync.delete();
    m_sync.push_back(1'b1);
    m_sync.push_back(1'b1);
  endtask

  task automatic model_step(output logic [5:0] exp_v);
    bit press, load, dec, zero, al, s2, fell;
    if (!drv_rst) begin
      model_reset();
      exp_v = '0;
      return;
    end
    press = m_press_next;
    load = 1'b0; dec = 1'b0; zero = 1'b0;
    if (m_mode == 0) load = press && !drv_pz;
    if (m_mode == 1) begin
      zero = drv_cz && !m_mask;
      dec  = !zero && !press && (m_phase == TICK - 1);
    end
    al = (m_mode == 3) && (((m_age / BLINK) % 2) == 0);
    exp_v = {load, dec, (m_mode == 1), al, 2'(m_mode)};
    case (m_mode)
      0: if (load) begin m_mode = 1; m_phase = 0; end
      1: begin
        if (zero) begin m_mode = 3; m_age = 0; end
        else if (press) m_mode = 2;
        else m_phase = (m_phase + 1) % TICK;
      end
      2: if (press) m_mode = 1;
      default: begin
        if (press || m_age == AT * TICK - 1) m_mode = 0;
        else m_age++;
      end
    endcase
    m_mask = load;
    s2 = m_sync[0];
    fell = 1'b0;
    if (s2 != m_lvl) begin
      m_streak++;
      if (m_streak == DB) begin
        m_lvl = s2;
        m_streak = 0;
        fell = !s2;
      end
    end else begin
      m_streak = 0;
    end
    m_press_next = fell;
    m_sync.push_back(drv_key1);
    void'(m_sync.pop_front());
  endtask

  // driver: one clock cycle, inputs applied at the falling edge, outputs sampled 1 ns later
  task automatic step();
    logic [5:0] exp_v, act_v;
    @(negedge clk);
    if (dp_auto) begin
      drv_pz = (dp_preset == 0);
      drv_cz = (dp_cnt == 0);
    end
    key = {drv_key1, drv_rst};
    cnt_zero = drv_cz;
    preset_zero = drv_pz;
    #1;
    o_load = cnt_load; o_dec = cnt_dec; o_run = run; o_alarm = alarm; o_st = st;
    cyc_n++;
    act_v = {o_load, o_dec, o_run, o_alarm, o_st};
    model_step(exp_v);
    check("model_outputs", act_v, exp_v);
    if (o_load) load_steps.push_back(cyc_n);
    if (o_dec) dec_steps.push_back(cyc_n);
    if (dp_auto) begin
      if (o_load) dp_cnt = dp_preset;
      else if (o_dec && dp_cnt > 0) dp_cnt--;
    end
  endtask

  task automatic hold(input logic k, input int n);
    drv_key1 = k;
    repeat (n) step();
  endtask

  // scoreboard: observed decrement cycles against the expected queue
  task automatic compare_decs(input string tag);
    check({tag, "_count"}, dec_steps.size(), exp_q.size());
    while (exp_q.size() > 0 && dec_steps.size() > 0)
      check(tag, dec_steps.pop_front(), int'(exp_q.pop_front()));
    exp_q.delete();
    dec_steps.delete();
  endtask

  typedef struct {
    logic       k;
    logic       cz;
    logic       pz;
    int         n;
    int         loads;
    int         decs;
    logic [1:0] st;
    logic       al;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int fall, l_step, a_step, rnd_end;
    vecs[0]  = '{1'b0, 1'b0, 1'b1,  8, 0, 0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0,  8, 0, 0, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0,  8, 1, 0, 2'd1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0,  9, 0, 1, 2'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0,  8, 0, 0, 2'd2, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 52, 0, 0, 2'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0,  7, 0, 0, 2'd2, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0,  4, 0, 1, 2'd1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 10, 0, 1, 2'd1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0,  2, 0, 0, 2'd3, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 30, 0, 0, 2'd0, 1'b0};

    model_reset();
    key = 2'b10; cnt_zero = 1'b0; preset_zero = 1'b0;

    // reset held 40 ns, then idle for 100 cycles
    drv_rst = 1'b0;
    hold(1'b1, 4);
    check("reset_st", o_st, 0);
    check("reset_outs", {o_load, o_dec, o_run, o_alarm}, 0);
    drv_rst = 1'b1;
    load_steps.delete(); dec_steps.delete();
    hold(1'b1, 100);
    check("idle_loads", load_steps.size(), 0);
    check("idle_decs", dec_steps.size(), 0);
    check("idle_st", o_st, 0);

    // bouncing key, then countdown from 00:03 into the alarm
    dp_auto = 1'b1; dp_preset = 3; dp_cnt = 3;
    load_steps.delete(); dec_steps.delete();
    repeat (3) begin hold(1'b0, 2); hold(1'b1, 2); end
    fall = cyc_n + 1;
    hold(1'b0, 12);
    check("db_load_count", load_steps.size(), 1);
    l_step = (load_steps.size() > 0) ? load_steps[0] : cyc_n;
    check("db_latency_in_window", int'((l_step - fall) >= 5 && (l_step - fall) <= 7), 1);
    check("start_st", o_st, 1);
    exp_q.push_back(W'(l_step + 10));
    exp_q.push_back(W'(l_step + 20));
    exp_q.push_back(W'(l_step + 30));
    hold(1'b1, l_step + 31 - cyc_n);
    compare_decs("countdown_dec");
    step();
    a_step = cyc_n;
    check("alarm_entry_st", o_st, 3);
    check("alarm_entry_level", o_alarm, 1);
    hold(1'b1, 5);
    check("alarm_blink_low", o_alarm, 0);
    hold(1'b1, 5);
    check("alarm_blink_high", o_alarm, 1);
    hold(1'b1, a_step + 29 - cyc_n);
    check("alarm_last_cycle_st", o_st, 3);
    step();
    check("alarm_expire_st", o_st, 0);
    check("alarm_expire_level", o_alarm, 0);
    dp_auto = 1'b0; drv_cz = 1'b0;

    // table: preset-zero press, start, pause at prescaler 6, resume, expiry
    load_steps.delete(); dec_steps.delete();
    for (int i = 0; i < 11; i++) begin
      automatic int l0 = load_steps.size();
      automatic int d0 = dec_steps.size();
      drv_key1 = vecs[i].k; drv_cz = vecs[i].cz; drv_pz = vecs[i].pz;
      repeat (vecs[i].n) step();
      check($sformatf("vec%0d_loads", i), load_steps.size() - l0, vecs[i].loads);
      check($sformatf("vec%0d_decs", i), dec_steps.size() - d0, vecs[i].decs);
      check($sformatf("vec%0d_st", i), o_st, vecs[i].st);
      check($sformatf("vec%0d_alarm", i), o_alarm, vecs[i].al);
    end
    drv_cz = 1'b0; drv_pz = 1'b0;

    // press during alarm returns to idle on the next edge
    dp_auto = 1'b1; dp_preset = 1; dp_cnt = 1;
    hold(1'b0, 8);
    hold(1'b1, 6);
    hold(1'b0, 6);
    step();
    check("alarm_press_before_st", o_st, 3);
    check("alarm_press_before_level", o_alarm, 1);
    step();
    check("alarm_press_after_st", o_st, 0);
    check("alarm_press_after_level", o_alarm, 0);
    dp_auto = 1'b0; drv_cz = 1'b0; drv_pz = 1'b0;
    hold(1'b1, 10);

    // asynchronous reset in the middle of RUN with the prescaler at 7
    hold(1'b0, 8);
    hold(1'b1, 7);
    check("run_before_reset", o_run, 1);
    #1;
    drv_rst = 1'b0;
    key = {drv_key1, 1'b0};
    #1;
    check("async_reset_st", st, 0);
    check("async_reset_outs", {cnt_load, cnt_dec, run, alarm}, 0);
    model_reset();
    hold(1'b1, 3);
    drv_rst = 1'b1;
    hold(1'b1, 10);
    load_steps.delete(); dec_steps.delete();
    hold(1'b0, 8);
    l_step = (load_steps.size() > 0) ? load_steps[0] : cyc_n;
    exp_q.push_back(W'(l_step + 10));
    hold(1'b1, 12);
    compare_decs("restart_dec");

    // randomized key, preset_zero, cnt_zero and occasional resets
    rnd_end = cyc_n + 1500;
    while (cyc_n < rnd_end) begin
      drv_key1 = 1'($urandom_range(0, 1));
      drv_pz = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 40) == 0) begin
        drv_rst = 1'b0;
        repeat (2) step();
        drv_rst = 1'b1;
      end
      repeat ($urandom_range(1, 14)) begin
        drv_cz = ($urandom_range(0, 15) == 0);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
